load_ext_ctrl: RTL and testbench
================================

// Module: load_ext_ctrl
// PURPOSE
//   Multi-cycle load sequencer between the MEM stage and the data-memory port.
//   Accepts one load (byte/half/word, signed/unsigned), issues a word-aligned read,
//   waits for the memory acknowledge, then extracts and sign/zero-extends the lane to 32 bits.
//   Drives busy to stall the pipeline. Reports misalignment and timeout instead of hanging.
// PARAMETERS
//   TIMEOUT   255  max cycles in WAIT without mem_ack before abort (1..255)
//   CNT_W     8    width of the timeout counter; must hold TIMEOUT
// PORTS
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   req         in   1   load request; sampled only in IDLE
//   addr        in   32  byte address of the load
//   size        in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   uns         in   1   1 = zero-extend (lbu/lhu), 0 = sign-extend
//   mem_req     out  1   read strobe to data memory, held until mem_ack
//   mem_addr    out  32  {addr[31:2],2'b00}, stable while mem_req=1
//   mem_ack     in   1   read data valid this cycle
//   mem_rdata   in   32  read word, little-endian lanes (byte0 = bits 7:0)
//   busy        out  1   1 whenever state != IDLE (pipeline stall)
//   done        out  1   one-cycle completion pulse
//   rdata       out  32  extended result, valid while done=1
//   addr_err    out  1   misaligned access, valid while done=1
//   tmo_err     out  1   timeout abort, valid while done=1
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; mem_req, busy, done, addr_err, tmo_err = 0;
//     rdata, mem_addr = 0; counter=0. Reset mid-transaction drops mem_req at once; no done.
//   All outputs are registered. Latched on accept: addr[1:0], size, uns.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: on req=1: if misaligned (half with addr[0]=1, word/11 with addr[1:0]!=0)
//     -> RESP with addr_err=1, rdata=0, mem_req never asserted.
//     Else -> WAIT; mem_req=1 and mem_addr set on the same edge; counter=0.
//   WAIT: mem_ack=1 -> capture lane, mem_req=0, -> RESP.
//     mem_ack=0 -> counter+1; when counter reaches TIMEOUT-1 without ack ->
//     mem_req=0, tmo_err=1, rdata=0, -> RESP.
//     mem_ack and timeout on the same cycle: ack wins.
//   RESP: done=1 for exactly one cycle, then IDLE; error flags clear with done.
//   Lane select: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
//   Extension: byte -> {24{uns?0:b[7]}, b}; half -> {16{uns?0:h[15]}, h}; word unchanged (uns ignored).
//   Latency: req at cycle 0 -> mem_req at 1; ack at cycle k -> done at k+1.
//     Misaligned: done at cycle 1. Min aligned load (ack at 1): done at 2.
//   req while busy=1 is ignored and not queued; the requester holds req until it sees done.
//   mem_ack outside WAIT is ignored.
//   busy=1 in WAIT and RESP; busy falls on the same edge done falls.
// TESTING
//   lb addr=0x1003 uns=0, rdata word 0x80FF_1234, ack at cycle 3 -> mem_addr=0x1000, done cycle 4, rdata=0xFFFF_FF80.
//   lhu addr=0x2002 uns=1, mem_rdata=0xBEEF_0001 -> rdata=0x0000_BEEF; lh same -> 0xFFFF_BEEF.
//   lw addr=0x3001 -> no mem_req, done at cycle 1, addr_err=1, rdata=0; lh addr=0x3001 -> same.
//   TIMEOUT=4, lw addr=0x40, no ack -> mem_req 4 cycles then 0, done with tmo_err=1; ack on the last cycle -> normal result.
//   rst_n low in WAIT -> mem_req, busy 0 immediately, no done; next req completes normally.
//   Second req while busy and stray mem_ack in IDLE -> ignored; back-to-back loads each give one done.

Source files
------------

// File: rtl/load_ext_ctrl.sv
`timescale 1ns/1ps
// Load sequencer between MEM stage and data-memory port: issues a word-aligned
// read, waits for ack (with timeout), then extracts and extends the addressed lane.
module load_ext_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             mem_req_q;
  logic [31:0]      mem_addr_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      rdata_q;
  logic             addr_err_q;
  logic             tmo_err_q;

  logic             misaligned;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [31:0]      rdata_d;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  // Lane extraction uses the offset/size/sign latched at accept, not the live inputs.
  always_comb begin
    byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
    half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
    rdata_d   = mem_rdata;
    case (size_q)
      2'b00:   rdata_d = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      2'b01:   rdata_d = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: rdata_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            off_q  <= addr[1:0];
            size_q <= size;
            uns_q  <= uns;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (misaligned) begin
              state_q    <= S_RESP;
              done_q     <= 1'b1;
              addr_err_q <= 1'b1;
              rdata_q    <= '0;
            end else begin
              state_q    <= S_WAIT;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {addr[31:2], 2'b00};
            end
          end
        end
        S_WAIT: begin
          // Ack takes priority over a timeout expiring on the same cycle.
          if (mem_ack) begin
            rdata_q   <= rdata_d;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_RESP;
          end else if (cnt_q == TMO_LAST) begin
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            tmo_err_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          done_q     <= 1'b0;
          addr_err_q <= 1'b0;
          tmo_err_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign addr_err = addr_err_q;
  assign tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_load_ext_ctrl.sv
`timescale 1ns/1ps
// Bench for load_ext_ctrl: directed and random loads against a behavioural reference.
module tb_load_ext_ctrl;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        tmo_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_ext_ctrl #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .size      (size),
    .uns       (uns),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .tmo_err   (tmo_err)
  );

  function automatic logic [31:0] ref_ext(input logic [31:0] a, input logic [1:0] sz,
                                          input logic u, input logic [31:0] w);
    longint v;
    int     off;
    off = int'(a % 4);
    case (sz)
      2'd0: begin
        v = (longint'(w) >> (8 * off)) & 255;
        if (!u && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (longint'(w) >> (16 * (off / 2))) & 65535;
        if (!u && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // Called at a negedge; that cycle is cycle 0. Ends at a negedge with the DUT idle.
  // ack_at: cycle in which mem_ack is driven (0 = never).
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] w, input int ack_at, input string tag);
    bit          mis;
    bit          exp_tmo;
    bit          exp_req;
    bit          exp_busy;
    bit          exp_done;
    int          done_cyc;
    logic [31:0] exp_rd;
    mis = ref_misaligned(a, sz);
    exp_tmo = 1'b0;
    if (mis) begin
      done_cyc = 1;
      exp_rd   = '0;
    end else if (ack_at >= 1 && ack_at <= int'(TMO)) begin
      done_cyc = ack_at + 1;
      exp_rd   = ref_ext(a, sz, u, w);
    end else begin
      done_cyc = int'(TMO) + 1;
      exp_rd   = '0;
      exp_tmo  = 1'b1;
    end
    req = 1'b1; addr = a; size = sz; uns = u; mem_ack = 1'b0; mem_rdata = $urandom;
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      @(negedge clk);
      exp_req  = !mis && (cyc < done_cyc);
      exp_busy = (cyc <= done_cyc);
      exp_done = (cyc == done_cyc);
      checks++;
      if (mem_req !== exp_req) begin
        errors++;
        $display("FAIL %s mem_req cyc=%0d got=%b exp=%b", tag, cyc, mem_req, exp_req);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, done, exp_done);
      end
      if (exp_req) begin
        checks++;
        if (mem_addr !== {a[31:2], 2'b00}) begin
          errors++;
          $display("FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, {a[31:2], 2'b00});
        end
      end
      if (exp_done) begin
        checks++;
        if (rdata !== exp_rd) begin
          errors++;
          $display("FAIL %s rdata got=%h exp=%h", tag, rdata, exp_rd);
        end
        checks++;
        if (addr_err !== mis) begin
          errors++;
          $display("FAIL %s addr_err got=%b exp=%b", tag, addr_err, mis);
        end
        checks++;
        if (tmo_err !== exp_tmo) begin
          errors++;
          $display("FAIL %s tmo_err got=%b exp=%b", tag, tmo_err, exp_tmo);
        end
      end
      // Requester keeps req high (with changing operands) until it sees done.
      if (cyc < done_cyc) begin
        addr = $urandom; size = 2'($urandom); uns = 1'($urandom);
      end else begin
        req = 1'b0;
      end
      mem_ack   = (cyc == ack_at);
      mem_rdata = (cyc == ack_at) ? w : $urandom;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; addr = '0; size = '0; uns = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if ({mem_req, busy, done, addr_err, tmo_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset flags got=%b exp=00000", {mem_req, busy, done, addr_err, tmo_err});
    end
    checks++;
    if (rdata !== 32'h0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset data rdata=%h mem_addr=%h exp=0", rdata, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy=%b done=%b exp=0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_load(32'h0000_1003, 2'd0, 1'b0, 32'h80FF_1234, 3, "lb_1003");
    run_load(32'h0000_2002, 2'd1, 1'b1, 32'hBEEF_0001, 1, "lhu_2002");
    run_load(32'h0000_2002, 2'd1, 1'b0, 32'hBEEF_0001, 2, "lh_2002");
    run_load(32'h0000_2001, 2'd0, 1'b1, 32'h1234_A5C3, 2, "lbu_2001");
    run_load(32'h0000_3001, 2'd2, 1'b0, 32'h1111_2222, 1, "lw_mis");
    run_load(32'h0000_3001, 2'd1, 1'b0, 32'h1111_2222, 1, "lh_mis");
    run_load(32'h0000_3002, 2'd3, 1'b0, 32'h1111_2222, 1, "l11_mis");
    run_load(32'h0000_3004, 2'd3, 1'b0, 32'h8765_4321, 2, "l11_word");
  endtask

  task automatic test_timeout();
    run_load(32'h0000_0040, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, "tmo_noack");
    run_load(32'h0000_0040, 2'd2, 1'b0, 32'hDEAD_BEEF, int'(TMO), "tmo_lastack");
    run_load(32'h0000_0040, 2'd2, 1'b0, 32'hDEAD_BEEF, int'(TMO) + 1, "tmo_lateack");
  endtask

  task automatic test_reset_mid();
    req = 1'b1; addr = 32'h0000_5008; size = 2'd2; uns = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid pre mem_req got=%b exp=1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, done} !== 3'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid flags got=%b mem_addr=%h exp=000/0", {mem_req, busy, done}, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid after done=%b busy=%b exp=0", done, busy);
      end
    end
    run_load(32'h0000_5008, 2'd2, 1'b0, 32'hCAFE_F00D, 2, "rstmid_next");
  endtask

  task automatic test_stray_ack();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({mem_req, busy, done} !== 3'b0) begin
        errors++;
        $display("FAIL stray_ack got=%b exp=000", {mem_req, busy, done});
      end
    end
    mem_ack = 1'b0;
    run_load(32'h0000_6001, 2'd0, 1'b0, 32'h0000_7F00, 1, "stray_next");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_load(32'h0000_7000 + 32'(i), 2'd0, 1'(i), 32'hF1E2_D3C4, 1 + i % 2, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_load($urandom, 2'($urandom), 1'($urandom), $urandom,
               int'($urandom_range(0, TMO + 2)), "rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_stray_ack();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
